row_skew_feeder: RTL and testbench
==================================

Name: row_skew_feeder

Overview:
- Upstream stage of the per-row input FIFO bank that feeds the systolic array.
- Accepts one activation column vector per beat over a valid/ready handshake and writes every row FIFO in lockstep.
- Skews the tile diagonally: row i is delayed by i steps and zero-padded, so the array reads all FIFOs together and sees a correctly staggered wavefront.
- Every row receives exactly TILE_LEN+NUM_ROWS-1 entries per tile.

Parameters:
- NUM_ROWS, 8, number of array rows / FIFOs fed.
- DATA_SIZE, 8, element width in bits.
- TILE_LEN, 8, columns per tile (data beats accepted per tile).
- STEP_W (localparam), clog2(TILE_LEN+NUM_ROWS), step counter width.

Ports:
- w_clk  in  1  clock, shared with the FIFO write side.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a tile; sampled only in IDLE.
- in_valid  in  1  in_data holds a valid column.
- in_ready  out  1  column accepted this cycle when in_valid&in_ready.
- in_data  in  NUM_ROWS*DATA_SIZE  column vector; row r at bits [r*DATA_SIZE +: DATA_SIZE].
- fifo_full  in  NUM_ROWS  per-row FIFO full flags.
- fifo_w_en  out  NUM_ROWS  per-row write enable; all bits are always equal.
- fifo_data  out  NUM_ROWS*DATA_SIZE  per-row write data, same packing as in_data.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last write of a tile.

Behaviour:
- Reset is synchronous, active-high, on w_clk.
  - State goes to IDLE; step counter and all delay registers go to 0.
  - in_ready, busy, done, fifo_w_en = 0; fifo_data = 0.
  - fifo_w_en and in_ready are additionally gated by ~reset, so no write or accept occurs during a reset cycle, even mid-tile.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN; step s=0; all skew registers cleared. Otherwise hold.
  - RUN: busy=1.
  - DONE: done=1 for one cycle -> IDLE. start is ignored in RUN and DONE.
- Stall and advance:
  - any_full = |fifo_full.
  - need_in = (s < TILE_LEN).
  - advance = RUN & ~any_full & (~need_in | in_valid).
  - in_ready = RUN & ~any_full & need_in; combinational, with no dependency on in_valid.
- On advance:
  - fifo_w_en = all ones in the same cycle (combinational).
  - The column for this step, col_in, is in_data if need_in, else 0.
  - s increments. If s == TILE_LEN+NUM_ROWS-2 before increment -> DONE.
- Skew delay line:
  - Row 0 tap = col_in row 0.
  - Row i>0 tap = register chain of depth i carrying row i of col_in; it shifts only on advance.
  - fifo_data row i = tap i.
  - Result: at step s, row i writes column (s-i) when 0 <= s-i < TILE_LEN, else 0.
- Stall rule: any single full flag stalls all rows. No partial writes; delay line, counter and outputs hold.
- in_valid while in_ready=0 (full, or s >= TILE_LEN) is not consumed; the upstream source holds it.
- Depth requirement: downstream FIFOs hold at least TILE_LEN+NUM_ROWS-1 entries, or the reader drains concurrently. Stalling on full is the only flow control.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default NUM_ROWS/DATA_SIZE/TILE_LEN constants, so the array, FIFO bank and feeder agree.
- One sub-module, skew_delay_line: a parameterised depth-D, DATA_SIZE-wide shift register with an enable and synchronous clear. Instantiated per row with D=i; D=0 is a pass-through.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Basic tile. Config: NUM_ROWS=4, TILE_LEN=4, in_valid held 1, columns k with row r = 8'h(10*k + r + 1). Start pulsed.
  - Required: 7 consecutive fifo_w_en=4'hF cycles.
  - Row0 writes 01,11,21,31,00,00,00.
  - Row3 writes 00,00,00,04,14,24,34.
  - done pulses the cycle after the 7th write; busy falls with it.
- FIFO stall. Same tile; fifo_full[2]=1 for 3 cycles at step 2.
  - Required: fifo_w_en=0 and in_ready=0 for those 3 cycles.
  - Written sequences are identical to the basic tile; done arrives 3 cycles later.
- Source gaps. in_valid toggles 1,0,1,0 during steps 0-3.
  - Required: no write on in_valid=0 cycles while s < 4.
  - Steps 4-6 advance with in_valid=0 and in_ready=0.
  - Data matches the basic tile.
- Reset mid-tile. Assert reset at step 3 for one cycle.
  - Required: no write in that cycle; state IDLE; all outputs 0.
  - A following start produces the basic-tile sequence exactly, with row3's first three entries 00 (delay cleared).
- Back-to-back tiles. Pulse start in RUN (ignored), then again in IDLE immediately after done.
  - Required: the first start has no effect.
  - The second tile's row1 first entry is 00, not leftover data from tile 1.

Source files
------------

// File: rtl/row_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_skew_feeder_pkg
// Description : Shared state encoding and default tile geometry for the
//               feeder, FIFO bank and systolic array.
// Revision    : 1.0
// ============================================================================
package row_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

  localparam int c_num_rows  = 8;
  localparam int c_data_size = 8;
  localparam int c_tile_len  = 8;

endpackage
`default_nettype wire

// File: rtl/row_skew_feeder_skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : DEPTH-stage shift register with enable and synchronous clear;
//               DEPTH=0 is a plain pass-through.
// Revision    : 1.0
// ============================================================================
module skew_delay_line #(
  parameter int DEPTH     = 1,
  parameter int DATA_SIZE = 8
) (
  input  logic                 w_clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = ^{w_clk, clr, en};
      assign dout     = din;
    end else begin : g_shift
      logic [DATA_SIZE-1:0] r_stage [DEPTH];

      always_ff @(posedge w_clk) begin
        if (clr) begin
          for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
        end else if (en) begin
          r_stage[0] <= din;
          for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : row_skew_feeder
// Description : Writes one tile into the per-row FIFOs with a diagonal skew,
//               row i delayed by i steps and zero padded.
// Revision    : 1.0
// ============================================================================
module row_skew_feeder
  import row_skew_feeder_pkg::*;
#(
  parameter int NUM_ROWS  = c_num_rows,
  parameter int DATA_SIZE = c_data_size,
  parameter int TILE_LEN  = c_tile_len
) (
  input  logic                          w_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_ROWS*DATA_SIZE-1:0] in_data,
  input  logic [NUM_ROWS-1:0]           fifo_full,
  output logic [NUM_ROWS-1:0]           fifo_w_en,
  output logic [NUM_ROWS*DATA_SIZE-1:0] fifo_data,
  output logic                          busy,
  output logic                          done
);

  localparam int                STEP_W = $clog2(TILE_LEN + NUM_ROWS);
  localparam logic [STEP_W-1:0] c_tile = STEP_W'(TILE_LEN);
  localparam logic [STEP_W-1:0] c_last = STEP_W'(TILE_LEN + NUM_ROWS - 2);

  feeder_state_t                 r_state;
  feeder_state_t                 w_state_nxt;
  logic [STEP_W-1:0]             r_step;
  logic                          w_run;
  logic                          w_any_full;
  logic                          w_need_in;
  logic                          w_advance;
  logic                          w_clr;
  logic [NUM_ROWS*DATA_SIZE-1:0] w_col_in;
  logic [NUM_ROWS*DATA_SIZE-1:0] w_taps;

  always_ff @(posedge w_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Reset gates the strobes so a mid-tile reset cycle never writes or accepts.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = (r_state == RUN);
    w_any_full  = |fifo_full;
    w_need_in   = (r_step < c_tile);
    w_advance   = w_run & ~w_any_full & (~w_need_in | in_valid) & ~reset;
    in_ready    = w_run & ~w_any_full & w_need_in & ~reset;
    w_clr       = reset | ((r_state == IDLE) & start);
    busy        = w_run;
    done        = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_advance && (r_step == c_last)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_clr)          r_step <= '0;
    else if (w_advance) r_step <= r_step + STEP_W'(1);
  end

  assign w_col_in = (w_run && w_need_in) ? in_data : '0;

  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      skew_delay_line #(
        .DEPTH     (gi),
        .DATA_SIZE (DATA_SIZE)
      ) u_dly (
        .w_clk (w_clk),
        .clr   (w_clr),
        .en    (w_advance),
        .din   (w_col_in[gi*DATA_SIZE +: DATA_SIZE]),
        .dout  (w_taps[gi*DATA_SIZE +: DATA_SIZE])
      );
    end
  endgenerate

  assign fifo_w_en = {NUM_ROWS{w_advance}};
  assign fifo_data = reset ? '0 : w_taps;

endmodule
`default_nettype wire

// File: tb/tb_row_skew_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_row_skew_feeder
// Description : Directed and random stimulus against a step-count model.
// Revision    : 1.0
// ============================================================================
module tb_row_skew_feeder;

  localparam int NR    = 4;
  localparam int DS    = 8;
  localparam int TL    = 4;
  localparam int NSTEP = TL + NR - 1;

  logic          w_clk = 1'b0;
  logic          reset, start, in_valid, in_ready, busy, done;
  logic [NR*DS-1:0] in_data, fifo_data;
  logic [NR-1:0] fifo_full, fifo_w_en;

  always #5 w_clk = ~w_clk;

  row_skew_feeder #(
    .NUM_ROWS  (NR),
    .DATA_SIZE (DS),
    .TILE_LEN  (TL)
  ) u_dut (
    .w_clk     (w_clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .fifo_full (fifo_full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DS-1:0] pat(input int k);
    logic [NR*DS-1:0] v;
    for (int r = 0; r < NR; r++) v[r*DS +: DS] = DS'(16*k + r + 1);
    return v;
  endfunction

  // Reference model: tile is a count of completed writes m_k
  bit               m_active = 0, m_done = 0, m_after_rst = 0;
  int               m_k = 0;
  logic [NR*DS-1:0] m_cols [TL];
  logic             mon_wen, mon_rdy;
  logic [NR*DS-1:0] mon_exp;
  int               mon_j;

  logic [DS-1:0] rec_row [NR][$];
  int            rec_nwr = 0;
  int            acc_cnt = 0;
  bit            acc_flag = 0;
  bit            src_rand = 0;
  int            cyc_cnt = 0;
  int            done_seen = 0;

  always @(posedge w_clk) cyc_cnt++;

  always @(negedge w_clk) begin
    mon_rdy = m_active && (fifo_full == '0) && (m_k < TL) && !reset;
    mon_wen = m_active && (fifo_full == '0) && (m_k >= TL || in_valid) && !reset;
    chk("in_ready", in_ready, mon_rdy);
    chk("fifo_w_en", fifo_w_en, {NR{mon_wen}});
    if (!reset) begin
      chk("busy", busy, m_active);
      chk("done", done, m_done);
    end
    if (m_after_rst) chk("post_reset_data", fifo_data, '0);
    if (mon_wen) begin
      for (int i = 0; i < NR; i++) begin
        mon_j = m_k - i;
        if (mon_j < 0 || mon_j >= TL)  mon_exp[i*DS +: DS] = '0;
        else if (mon_j == m_k)         mon_exp[i*DS +: DS] = in_data[i*DS +: DS];
        else                           mon_exp[i*DS +: DS] = m_cols[mon_j][i*DS +: DS];
      end
      chk("fifo_data", fifo_data, mon_exp);
    end
    if (fifo_w_en[0] === 1'b1) begin
      rec_nwr++;
      for (int i = 0; i < NR; i++) rec_row[i].push_back(fifo_data[i*DS +: DS]);
    end
    if (done === 1'b1) done_seen++;
    acc_flag = (in_valid && in_ready === 1'b1);
    if (acc_flag) acc_cnt++;
    m_after_rst = reset;
    if (reset) begin
      m_active = 0; m_done = 0; m_k = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin m_active = 1; m_k = 0; end
    end else if (mon_wen) begin
      if (m_k < TL) m_cols[m_k] = in_data;
      m_k++;
      if (m_k == NSTEP) begin m_active = 0; m_done = 1; end
    end
  end

  // Upstream source: presents a new column only after the previous one is taken
  always @(posedge w_clk) begin
    #1;
    if (acc_flag) in_data = src_rand ? (NR*DS)'($urandom) : pat(acc_cnt);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  int t0;

  task automatic begin_tile();
    acc_cnt = 0;
    in_data = pat(0);
    for (int r = 0; r < NR; r++) rec_row[r].delete();
    rec_nwr = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic wait_done(input string tag, input int lim, input int exp_lat);
    int n;
    n = 0;
    while (n < lim) begin
      @(negedge w_clk);
      if (done === 1'b1) break;
      n++;
    end
    if (n >= lim) chk({tag, "_done_timeout"}, done, 1'b1);
    else          chk({tag, "_latency"}, cyc_cnt - t0, exp_lat);
    tick(1);
  endtask

  task automatic check_seq(input string tag);
    logic [DS-1:0] e;
    int j;
    chk({tag, "_nwr"}, rec_nwr, NSTEP);
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < NSTEP && s < rec_row[r].size(); s++) begin
        j = s - r;
        e = (j >= 0 && j < TL) ? DS'(16*j + r + 1) : '0;
        chk($sformatf("%s_r%0d_s%0d", tag, r, s), rec_row[r][s], e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; fifo_full = '0; in_data = '0;
    tick(3);
    reset = 1'b0;
    tick(2);

    in_valid = 1'b1;
    begin_tile();
    wait_done("basic", 40, NSTEP);
    check_seq("basic");

    begin_tile();
    tick(2);
    fifo_full = 4'b0100;
    tick(3);
    fifo_full = '0;
    wait_done("stall", 40, NSTEP + 3);
    check_seq("stall");

    begin_tile();
    for (int c = 0; c < 20 && acc_cnt < TL; c++) begin
      in_valid = (c % 2 == 0);
      tick(1);
    end
    in_valid = 1'b0;
    wait_done("gaps", 40, NSTEP + 3);
    check_seq("gaps");

    in_valid = 1'b1;
    begin_tile();
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    begin_tile();
    wait_done("after_reset", 40, NSTEP);
    check_seq("after_reset");

    begin_tile();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("b2b_first", 40, NSTEP);
    begin_tile();
    wait_done("b2b_second", 40, NSTEP);
    check_seq("b2b_second");

    src_rand = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      fifo_full = (($urandom % 6) == 0) ? NR'(1 << ($urandom % NR)) : '0;
      start     = ($urandom % 5) == 0;
      reset     = ($urandom % 80) == 0;
      tick(1);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; fifo_full = '0;
    tick(2);
    chk("random_tiles_completed", done_seen > 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
